mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared asynchronous-read 32-bit memory (ports enable, ReadWrite, Address, DataIn, DataOut). It serialises requests from the instruction-fetch port (port 0) and the load/store port (port 1) into single memory accesses, and returns read data with a one-cycle acknowledge pulse. It sits between the CPU front end / execute stage and the `memory` instance; nothing else drives the memory.

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the shared asynchronous-read memory: IDLE -> ACCESS -> DONE per access.
// Define ARB_ROUND_ROBIN_EN for round-robin contested grants; default is fixed priority to port 1.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  busy,
    output logic                  mem_enable,
    output logic                  mem_rw,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_sel;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_last_grant;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;

    logic                  w_any_req;
    logic                  w_contest_winner;
    logic                  w_grant_sel;
    logic                  w_grant_we;
    logic [ADDR_WIDTH-1:0] w_grant_addr;
    logic [DATA_WIDTH-1:0] w_grant_wdata;

    assign w_any_req = req0 | req1;

`ifdef ARB_ROUND_ROBIN_EN
    assign w_contest_winner = ~r_last_grant;
`else
    // Fixed priority: port 1 always wins; last_grant is tracked but cannot change the result.
    assign w_contest_winner = r_last_grant | 1'b1;
`endif

    assign w_grant_sel   = (req0 & req1) ? w_contest_winner : req1;
    assign w_grant_we    = w_grant_sel ? we1    : we0;
    assign w_grant_addr  = w_grant_sel ? addr1  : addr0;
    assign w_grant_wdata = w_grant_sel ? wdata1 : wdata0;

    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;

    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b1;
        ack0         = 1'b0;
        ack1         = 1'b0;
        mem_enable   = 1'b0;
        mem_rw       = 1'b0;
        mem_addr     = '0;
        mem_din      = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_any_req) begin
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_enable   = 1'b1;
                mem_rw       = r_we;
                mem_addr     = r_addr;
                mem_din      = r_wdata;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                ack0         = ~r_sel;
                ack1         = r_sel;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments here so every register samples pre-edge values together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sel        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_last_grant <= 1'b1;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && w_any_req) begin
                r_sel   <= w_grant_sel;
                r_we    <= w_grant_we;
                r_addr  <= w_grant_addr;
                r_wdata <= w_grant_wdata;
            end
            // Memory read is combinational, so the data is valid at the edge closing ACCESS.
            if (r_state == S_ACCESS && !r_we) begin
                if (r_sel) begin
                    r_rdata1 <= mem_dout;
                end else begin
                    r_rdata0 <= mem_dout;
                end
            end
            if (r_state == S_DONE) begin
                r_last_grant <= r_sel;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts each access,
// a negedge monitor compares bus activity, acks and read data cycle by cycle.
module tb_mem_arbiter;

    typedef struct {
        int          port;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_cyc;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1, busy, mem_enable, mem_rw;
    logic [31:0] rdata0, rdata1, mem_din, mem_dout;
    logic [15:0] mem_addr;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc;
    txn_t exp_q[$];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .we0        (we0),
        .we1        (we1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .ack0       (ack0),
        .ack1       (ack1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .busy       (busy),
        .mem_enable (mem_enable),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 3) return 32'hDEADBEEF;
        return (32'h9E3779B9 * 32'(i + 7)) ^ 32'h5A5A0000;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Shared memory: asynchronous read, write on the rising edge while enabled.
    logic [31:0] tb_mem [0:255];
    assign mem_dout = tb_mem[mem_addr[7:0]];
    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_enable && mem_rw) tb_mem[mem_addr[7:0]] <= mem_din;
        end
    end

    // Reference model: an access is granted whenever the arbiter is free and a request
    // is seen; it occupies that cycle plus two more, with the ack in the last one.
    initial begin
        logic [31:0] model_mem [0:255];
        int          next_free;
        logic        last_grant;
        logic        win;
        txn_t        t;
        for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
        cyc        = 0;
        next_free  = 0;
        last_grant = 1'b1;
        forever begin
            @(posedge clk);
            if (reset) begin
                exp_q.delete();
                next_free  = cyc + 1;
                last_grant = 1'b1;
            end else if (cyc >= next_free && (req0 || req1)) begin
                if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
                    win = ~last_grant;
`else
                    win = 1'b1;
`endif
                end else begin
                    win = req1;
                end
                t.port    = win ? 1 : 0;
                t.we      = win ? we1 : we0;
                t.addr    = win ? addr1 : addr0;
                t.wdata   = win ? wdata1 : wdata0;
                t.ack_cyc = cyc + 2;
                if (t.we) begin
                    model_mem[t.addr[7:0]] = t.wdata;
                    t.rdata = 32'h0;
                end else begin
                    t.rdata = model_mem[t.addr[7:0]];
                end
                exp_q.push_back(t);
                next_free  = cyc + 3;
                last_grant = win;
            end
            cyc++;
        end
    end

    // Monitor: compares the DUT every cycle against the head of the expected queue.
    initial begin
        txn_t        t;
        bit          has, in_acc, in_done;
        logic [31:0] exp_rd0, exp_rd1;
        exp_rd0 = 32'h0;
        exp_rd1 = 32'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_rd0 = 32'h0;
                exp_rd1 = 32'h0;
            end else begin
                has = (exp_q.size() != 0);
                if (has) t = exp_q[0];
                in_acc  = has && (cyc == t.ack_cyc - 1);
                in_done = has && (cyc == t.ack_cyc);
                if (in_done && !t.we) begin
                    if (t.port == 1) exp_rd1 = t.rdata;
                    else             exp_rd0 = t.rdata;
                end
                check("busy", busy, in_acc || in_done);
                check("mem_enable", mem_enable, in_acc);
                check("mem_bus", {15'b0, mem_rw, mem_addr, mem_din},
                      in_acc ? {15'b0, t.we, t.addr, t.wdata} : 64'h0);
                check("ack0", ack0, in_done && t.port == 0);
                check("ack1", ack1, in_done && t.port == 1);
                check("rdata0", rdata0, exp_rd0);
                check("rdata1", rdata1, exp_rd1);
                if (has && cyc > t.ack_cyc) begin
                    check("ack_missing", 1'b1, 1'b0);
                    void'(exp_q.pop_front());
                end
                if (in_done) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [15:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic rand_req(input int p);
        drive(p, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), $urandom());
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds requests until acked, dropping each on the edge after its ack.
    task automatic serve(input int max_cycles);
        int k = 0;
        bit a0, a1;
        while ((req0 || req1) && k < max_cycles) begin
            @(negedge clk);
            a0 = ack0;
            a1 = ack1;
            @(posedge clk);
            #1;
            if (a0) req0 = 1'b0;
            if (a1) req1 = 1'b0;
            k++;
        end
        check("serve_done", {req0, req1}, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit a0, a1;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
        idle(3);
        reset = 1'b0;
        idle(1);

        // Single read from port 0 of a preloaded word.
        drive(0, 1'b1, 1'b0, 16'h0003, 32'hA5A5A5A5);
        serve(20);
        check("t1_rdata0", rdata0, 32'hDEADBEEF);
        idle(2);

        // Port 1 write followed by port 0 read of the same address.
        drive(1, 1'b1, 1'b1, 16'h0005, 32'h12345678);
        serve(20);
        drive(0, 1'b1, 1'b0, 16'h0005, 32'h0);
        serve(20);
        check("t2_rdata0", rdata0, 32'h12345678);
        check("t2_rdata1", rdata1, 32'h0);
        idle(2);

        // Both ports held high continuously.
        drive(0, 1'b1, 1'b0, 16'h0000, 32'h0);
        drive(1, 1'b1, 1'b0, 16'h0001, 32'h0);
        idle(12);
        drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
        idle(4);

        // Simultaneous first requests straight after reset.
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, 16'h0008, 32'h0);
        drive(1, 1'b1, 1'b0, 16'h0009, 32'h0);
        serve(20);
        idle(2);

        // Reset in the middle of a port 1 read.
        drive(1, 1'b1, 1'b0, 16'h0003, 32'h0);
        serve(20);
        check("t5_rdata1_pre", rdata1, 32'hDEADBEEF);
        idle(1);
        drive(1, 1'b1, 1'b0, 16'h0007, 32'h0);
        idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
        check("t5_busy", busy, 1'b0);
        check("t5_rdata1", rdata1, 32'h0);
        idle(3);

        // Port 0 request raised while port 1 is in DONE.
        drive(1, 1'b1, 1'b0, 16'h000A, 32'h0);
        idle(2);
        drive(0, 1'b1, 1'b0, 16'h000B, 32'h0);
        idle(1);
        drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
        serve(20);
        idle(2);

        // Random traffic on both ports.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            a0 = ack0;
            a1 = ack1;
            @(posedge clk);
            #1;
            if (req0 && a0) begin
                if ($urandom_range(0, 1) == 1) rand_req(0);
                else req0 = 1'b0;
            end else if (!req0 && $urandom_range(0, 3) == 0) begin
                rand_req(0);
            end
            if (req1 && a1) begin
                if ($urandom_range(0, 1) == 1) rand_req(1);
                else req1 = 1'b0;
            end else if (!req1 && $urandom_range(0, 3) == 0) begin
                rand_req(1);
            end
        end
        serve(60);
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
